alu_arbiter_ctrl: RTL and testbench

Shares the single 32-bit ALU between two requesters, e.g. port 0 = execute stage and port 1 = address/multi-cycle unit.
- Arbitrates requests round-robin.
- Registers the operands and opcode, drives the ALU and captures its result and NZCV flags.
- Owns the architectural condition-code register.
- Returns the result to the winning requester over a valid/ready response handshake.
- Sits between the decode/issue logic and the ALU instance; the ALU is outside this block and connected by ports.

---
 rtl/alu_arbiter_ctrl_pkg.sv | 21 ++
 rtl/alu_arbiter_ctrl_rr.sv | 20 ++
 rtl/alu_arbiter_ctrl.sv | 103 ++++++++++
 tb/tb_alu_arbiter_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_ctrl_pkg.sv
// Shared constants for the ALU arbiter/controller slice: opcode encodings,
// controller state encoding and condition-code bit positions.
package alu_arbiter_ctrl_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_ADC = 4'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_arbiter_ctrl_rr.sv
// Two-way round-robin grant: a lone requester always wins, and on a tie
// the requester that did not win last time gets the grant.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       any,
  output logic       gnt
);

  always_comb begin
    any = |valid;
    case (valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Shares one external ALU between two requesters: round-robin grant, operand
// registration, result/flag capture, condition-code register and response handshake.
module alu_arbiter_ctrl
  import alu_arbiter_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_s,
  output logic [1:0]       req_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_ci,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_co,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic [3:0]       rsp_nzcv,
  input  logic             rsp_ready,
  output logic [3:0]       flags
);

  logic [1:0] state;
  logic       last;
  logic       id_q;
  logic       s_q;
  logic       any;
  logic       gnt;
  logic [3:0] nzcv;

  rr_arbiter2 u_arb (
    .valid (req_valid),
    .last  (last),
    .any   (any),
    .gnt   (gnt)
  );

  assign nzcv      = {alu_n, alu_z, alu_co, alu_v};
  assign alu_ci    = flags[FLAG_C];
  // Decoded from state so an asynchronous reset drops it without a clock edge.
  assign rsp_valid = (state == ST_RESP);

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && any) req_ready = gnt ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      id_q     <= 1'b0;
      s_q      <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rsp_y    <= '0;
      rsp_nzcv <= '0;
      rsp_id   <= 1'b0;
      flags    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            alu_op <= gnt ? req_op1 : req_op0;
            alu_a  <= gnt ? req_a1  : req_a0;
            alu_b  <= gnt ? req_b1  : req_b0;
            s_q    <= req_s[gnt];
            id_q   <= gnt;
            last   <= gnt;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_y    <= alu_y;
          rsp_nzcv <= nzcv;
          rsp_id   <= id_q;
          if (s_q) flags <= nzcv;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Self-checking bench for alu_arbiter_ctrl: an ALU stub answers the DUT, and a
// transaction-level model (grant rule, flag register, pointer) predicts every response.
module tb_alu_arbiter_ctrl;
  import alu_arbiter_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]  req_s;
  logic [1:0]  req_ready;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_op;
  logic        alu_ci, alu_n, alu_z, alu_v, alu_co;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [31:0] rsp_y;
  logic [3:0]  rsp_nzcv, flags;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic       m_last;
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  alu_arbiter_ctrl #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_s(req_s), .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ci(alu_ci),
    .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_co(alu_co),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_nzcv(rsp_nzcv),
    .rsp_ready(rsp_ready), .flags(flags)
  );

  // Returns {N,Z,C,V,y}.
  function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci);
    logic [32:0] s;
    logic [31:0] y;
    logic        c, v;
    s = '0; y = b; c = 1'b0; v = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b}; y = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; y = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (y[31] != a[31]);
      end
      OP_ADC: begin
        s = {1'b0, a} + {1'b0, b} + {32'd0, ci}; y = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      default: y = b;
    endcase
    return {y[31], (y == 32'd0), c, v, y};
  endfunction

  logic [35:0] stub;
  always_comb stub = ref_alu(alu_op, alu_a, alu_b, alu_ci);
  assign alu_y  = stub[31:0];
  assign alu_n  = stub[35];
  assign alu_z  = stub[34];
  assign alu_co = stub[33];
  assign alu_v  = stub[32];

  // A grant must never coincide with an outstanding response.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      vectors++;
      if (rsp_valid === 1'b1 && req_ready !== 2'b00) begin
        miscompares++;
        $display("FAIL grant_during_resp t=%0t req_ready=%b required 00", $time, req_ready);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Called at a negedge with the DUT idle; returns the granted requester.
  task automatic issue(input logic [1:0] v, input logic [3:0] o0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic [3:0] o1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [1:0] s, input int unsigned hold,
                       output logic g);
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        ss;
    logic [35:0] r;
    req_valid = v; req_op0 = o0; req_a0 = a0; req_b0 = b0;
    req_op1 = o1; req_a1 = a1; req_b1 = b1; req_s = s; rsp_ready = 1'b0;
    #1;
    g  = (v == 2'b11) ? ~m_last : v[1];
    op = g ? o1 : o0; a = g ? a1 : a0; b = g ? b1 : b0; ss = s[g];
    vectors++;
    if (req_ready !== (g ? 2'b10 : 2'b01)) begin
      miscompares++;
      $display("FAIL grant_ready got=%b required=%b", req_ready, g ? 2'b10 : 2'b01);
    end
    @(negedge clk);
    // Operand buses change while the op executes; the latched copy must not.
    req_a0 = $urandom; req_a1 = $urandom; req_b0 = $urandom; req_b1 = $urandom;
    req_op0 = 4'($urandom); req_op1 = 4'($urandom); req_s = 2'($urandom);
    vectors++;
    if ({req_ready, rsp_valid, alu_op, alu_a, alu_b, alu_ci} !==
        {2'b00, 1'b0, op, a, b, m_flags[FLAG_C]}) begin
      miscompares++;
      $display("FAIL exec_regs got rdy=%b v=%b op=%h a=%h b=%h ci=%b required rdy=00 v=0 op=%h a=%h b=%h ci=%b",
               req_ready, rsp_valid, alu_op, alu_a, alu_b, alu_ci, op, a, b, m_flags[FLAG_C]);
    end
    r = ref_alu(op, a, b, m_flags[FLAG_C]);
    m_last = g;
    if (ss) m_flags = r[35:32];
    @(negedge clk);
    for (int i = 0; i <= int'(hold); i++) begin
      vectors++;
      if ({rsp_valid, rsp_id, rsp_nzcv, rsp_y, flags, req_ready} !==
          {1'b1, g, r[35:32], r[31:0], m_flags, 2'b00}) begin
        miscompares++;
        $display("FAIL resp cyc=%0d got v=%b id=%b nzcv=%b y=%h flags=%b rdy=%b required v=1 id=%b nzcv=%b y=%h flags=%b rdy=00",
                 i, rsp_valid, rsp_id, rsp_nzcv, rsp_y, flags, req_ready, g, r[35:32], r[31:0], m_flags);
      end
      if (i < int'(hold)) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_release got rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic pulse_reset();
    req_valid = 2'b00;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_last = 1'b1; m_flags = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0; req_s = '0;
    m_last = 1'b1; m_flags = 4'b0000;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, rsp_id, rsp_y, rsp_nzcv, alu_a, alu_b, alu_op, flags} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got rdy=%b v=%b id=%b y=%h nzcv=%b a=%h b=%h op=%h flags=%b required all zero",
               req_ready, rsp_valid, rsp_id, rsp_y, rsp_nzcv, alu_a, alu_b, alu_op, flags);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_add();
    logic g;
    issue(2'b01, OP_ADD, 32'd10, 32'd15, OP_AND, 32'd0, 32'd0, 2'b01, 0, g);
    vectors++;
    if ({g, flags} !== {1'b0, 4'b0000}) begin
      miscompares++;
      $display("FAIL basic_add got g=%b flags=%b required g=0 flags=0000", g, flags);
    end
  endtask

  task automatic test_flags();
    logic g;
    req_valid = 2'b00;
    issue(2'b01, OP_ADD, 32'hFFFF_FFFF, 32'd1, OP_AND, 32'd0, 32'd0, 2'b01, 0, g);
    vectors++;
    if (flags !== 4'b0110) begin
      miscompares++;
      $display("FAIL flags_after_add got=%b required=0110", flags);
    end
    issue(2'b01, OP_AND, 32'hFFFF_FFF0, 32'h0000_000F, OP_AND, 32'd0, 32'd0, 2'b00, 1, g);
    vectors++;
    if (flags !== 4'b0110) begin
      miscompares++;
      $display("FAIL flags_kept_s0 got=%b required=0110", flags);
    end
    issue(2'b10, OP_AND, 32'd0, 32'd0, OP_ADC, 32'd5, 32'd6, 2'b10, 0, g);
  endtask

  task automatic test_back_to_back();
    logic g;
    time  t_prev, t_now;
    pulse_reset();
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      t_now = $time;
      issue(2'b11, OP_ADD, 32'($urandom), 32'($urandom), OP_SUB, 32'($urandom),
            32'($urandom), 2'b11, 0, g);
      vectors++;
      if (g !== 1'(i % 2) || (i > 0 && t_now - t_prev != 30)) begin
        miscompares++;
        $display("FAIL rr_order i=%0d got g=%b gap=%0t required g=%0d gap=30", i, g, t_now - t_prev, i % 2);
      end
      t_prev = t_now;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    logic g;
    issue(2'b10, OP_AND, 32'd0, 32'd0, OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 2'b00, 5, g);
    issue(2'b10, OP_AND, 32'd0, 32'd0, OP_SUB, 32'd3, 32'd9, 2'b10, 0, g);
    vectors++;
    if (g !== 1'b1) begin
      miscompares++;
      $display("FAIL pending_grant got g=%b required 1", g);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic g;
    for (int k = 0; k < 2; k++) begin
      issue(2'b01, OP_ADD, 32'h7FFF_FFFF, 32'd1, OP_AND, 32'd0, 32'd0, 2'b01, 0, g);
      req_valid = 2'b01; req_op0 = OP_ADD; req_a0 = 32'd1; req_b0 = 32'd2; req_s = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      if (k == 1) begin
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL pre_abort_resp got rsp_valid=%b required 1", rsp_valid);
        end
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({rsp_valid, flags} !== 5'b0) begin
        miscompares++;
        $display("FAIL async_abort k=%0d got rsp_valid=%b flags=%b required 0 0000", k, rsp_valid, flags);
      end
      #1 rst_n = 1'b1;
      m_last = 1'b1; m_flags = 4'b0000;
      @(negedge clk);
    end
    issue(2'b11, OP_OR, 32'hA0, 32'h0B, OP_ADD, 32'd1, 32'd1, 2'b11, 0, g);
    vectors++;
    if (g !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_winner got g=%b required 0", g);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_random();
    logic       g;
    logic [3:0] ops [6];
    ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_XOR;
    ops[3] = OP_ADD; ops[4] = OP_SUB; ops[5] = OP_ADC;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 2'b00;
        @(negedge clk);
      end
      issue(2'($urandom_range(1, 3)), ops[$urandom_range(0, 5)], 32'($urandom), 32'($urandom),
            ops[$urandom_range(0, 5)], 32'($urandom), 32'($urandom), 2'($urandom),
            $urandom_range(0, 3), g);
    end
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_flags();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
